// File: rtl/ins_decode_stage_if.sv
// Fetch-to-decode bundle bus: upstream instruction bundle in, pre-decoded bundle out.
interface ins_decode_stage_if #(
   parameter int LANES = 2
);
   logic                  in_valid;
   logic                  in_ready;
   logic [LANES-1:0]      in_mask;
   logic [32*LANES-1:0]   ins;
   logic                  out_valid;
   logic                  out_ready;
   logic [LANES-1:0]      out_mask;
   logic [3*LANES-1:0]    lane_type;
   logic [32*LANES-1:0]   imm;
   logic [LANES-1:0]      illegal;

   modport slave (
      input  in_valid, in_mask, ins, out_ready,
      output in_ready, out_valid, out_mask, lane_type, imm, illegal
   );

   modport master (
      output in_valid, in_mask, ins, out_ready,
      input  in_ready, out_valid, out_mask, lane_type, imm, illegal
   );
endinterface

// File: rtl/ins_decode_stage.sv
// Multi-lane RV32 pre-decode stage: opcode class, immediate and illegal flag per lane,
// registered behind an output register plus one-entry skid buffer.
module ins_decode_stage #(
   parameter int LANES = 2,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   flush,
   ins_decode_stage_if.slave      bus,
   output logic [CNT_W-1:0]       stall_cnt
);

   typedef enum logic [2:0] {
      RTYPE = 3'd0,
      ITYPE = 3'd1,
      STYPE = 3'd2,
      BTYPE = 3'd3,
      UTYPE = 3'd4,
      JTYPE = 3'd5,
      NTYPE = 3'd6
   } ins_type_e;

   typedef struct packed {
      ins_type_e   typ;
      logic [31:0] imm;
      logic        illegal;
   } lane_t;

   typedef struct packed {
      logic [LANES-1:0]        mask;
      logic [LANES-1:0][2:0]   typ;
      logic [LANES-1:0][31:0]  imm;
      logic [LANES-1:0]        illegal;
   } bundle_t;

   function automatic lane_t decode_lane(input logic [31:0] w, input logic en);
      lane_t r;
      r.typ     = NTYPE;
      r.imm     = '0;
      r.illegal = 1'b0;
      if (en) begin
         if (w[1:0] != 2'b11) begin
            r.illegal = 1'b1;
         end else begin
            case (w[6:0])
               7'b0110111, 7'b0010111:                       r.typ = UTYPE;
               7'b1101111:                                   r.typ = JTYPE;
               7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: r.typ = ITYPE;
               7'b1100011:                                   r.typ = BTYPE;
               7'b0100011:                                   r.typ = STYPE;
               7'b0110011, 7'b0101111:                       r.typ = RTYPE;
               7'b0001111:                                   r.typ = NTYPE;
               default:                                      r.illegal = 1'b1;
            endcase
         end
         case (r.typ)
            ITYPE:   r.imm = {{20{w[31]}}, w[31:20]};
            STYPE:   r.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            BTYPE:   r.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            UTYPE:   r.imm = {w[31:12], 12'h000};
            JTYPE:   r.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: r.imm = '0;
         endcase
      end
      return r;
   endfunction

   bundle_t dec;
   bundle_t or_q;
   bundle_t sr_q;
   logic    or_valid;
   logic    sr_valid;
   logic    in_fire;

   // NOTE: every field gets a default before the loop so no path leaves dec unassigned (no latch).
   always_comb begin
      dec      = '0;
      dec.mask = bus.in_mask;
      for (int l = 0; l < LANES; l++) begin
         lane_t r;
         r              = decode_lane(bus.ins[32*l +: 32], bus.in_mask[l]);
         dec.typ[l]     = r.typ;
         dec.imm[l]     = r.imm;
         dec.illegal[l] = r.illegal;
      end
   end

   // Ready depends only on skid occupancy, which keeps OUT_READY off the upstream timing path.
   assign bus.in_ready  = ~sr_valid;
   assign in_fire       = bus.in_valid & ~sr_valid;

   assign bus.out_valid = or_valid;
   assign bus.out_mask  = or_q.mask;
   assign bus.lane_type = or_q.typ;
   assign bus.imm       = or_q.imm;
   assign bus.illegal   = or_q.illegal;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the data registers are reset too, because they drive the outputs directly and must read zero.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         or_valid <= 1'b0;
         sr_valid <= 1'b0;
         or_q     <= '0;
         sr_q     <= '0;
      end else if (flush) begin
         or_valid <= 1'b0;
         sr_valid <= 1'b0;
      end else if (or_valid && bus.out_ready) begin
         if (sr_valid) begin
            or_q     <= sr_q;
            sr_valid <= 1'b0;
         end else if (in_fire) begin
            or_q     <= dec;
         end else begin
            or_valid <= 1'b0;
         end
      end else if (!or_valid) begin
         if (in_fire) begin
            or_q     <= dec;
            or_valid <= 1'b1;
         end
      end else if (in_fire) begin
         sr_q     <= dec;
         sr_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cnt <= '0;
      end else if (or_valid && !bus.out_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ins_decode_stage.sv
// Scoreboard bench for ins_decode_stage: stimulus pushes reference-model results, a monitor pops them.
module tb_ins_decode_stage;

   localparam int L = 2;

   typedef struct {
      logic [L-1:0]    mask;
      logic [3*L-1:0]  typ;
      logic [32*L-1:0] imm;
      logic [L-1:0]    illegal;
   } exp_t;

   logic clk;
   logic rstn;
   logic flush;
   logic [15:0] stall_cnt;
   logic [3:0]  stall_sat;

   ins_decode_stage_if #(.LANES(L)) bif ();
   ins_decode_stage_if #(.LANES(L)) sif ();

   ins_decode_stage #(.LANES(L), .CNT_W(16)) dut (
      .clk(clk), .rstn(rstn), .flush(flush), .bus(bif), .stall_cnt(stall_cnt)
   );

   ins_decode_stage #(.LANES(L), .CNT_W(4)) dut_sat (
      .clk(clk), .rstn(rstn), .flush(1'b0), .bus(sif), .stall_cnt(stall_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_out = 0;
   exp_t q[$];
   exp_t head;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Reference decode: classify by opcode value, then assemble the immediate from bit fields arithmetically.
   function automatic exp_t model(input logic [L-1:0] m, input logic [32*L-1:0] words);
      exp_t e;
      e.mask = m;
      e.typ = '0;
      e.imm = '0;
      e.illegal = '0;
      for (int l = 0; l < L; l++) begin
         bit [31:0] w, im, sx;
         int t;
         bit il;
         w  = words[32*l +: 32];
         t  = 6;
         im = 0;
         il = 0;
         if (m[l]) begin
            if ((w & 3) != 3) il = 1;
            else case (w & 32'h7F)
               32'h37, 32'h17:                 t = 4;
               32'h6F:                         t = 5;
               32'h67, 32'h03, 32'h13, 32'h73: t = 1;
               32'h63:                         t = 3;
               32'h23:                         t = 2;
               32'h33, 32'h2F:                 t = 0;
               32'h0F:                         t = 6;
               default:                        il = 1;
            endcase
            if (il) t = 6;
            sx = w[31] ? 32'hFFFF_FFFF : 32'h0;
            if (!il) case (t)
               1: im = (sx & 32'hFFFF_F000) | (w >> 20);
               2: im = (sx & 32'hFFFF_F000) | ((w >> 20) & 32'hFE0) | ((w >> 7) & 32'h1F);
               3: im = (sx & 32'hFFFF_F000) | (((w >> 7) & 1) << 11) | (((w >> 25) & 32'h3F) << 5)
                       | (((w >> 8) & 32'hF) << 1);
               4: im = w & 32'hFFFF_F000;
               5: im = (sx & 32'hFFF0_0000) | (w & 32'h000F_F000) | (((w >> 20) & 1) << 11)
                       | (((w >> 21) & 32'h3FF) << 1);
               default: im = 0;
            endcase
         end
         e.typ[3*l +: 3]   = 3'(t);
         e.imm[32*l +: 32] = im;
         e.illegal[l]      = il;
      end
      return e;
   endfunction

   // Every output-valid cycle is compared: held cycles for stability, transfer cycles consume the entry.
   always @(negedge clk) begin
      if (rstn && bif.out_valid) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got mask %b, required no output", bif.out_mask);
         end else begin
            string tag;
            head = q[0];
            tag  = bif.out_ready ? "out" : "held";
            check({tag, "_mask"},    bif.out_mask,  head.mask);
            check({tag, "_type"},    bif.lane_type, head.typ);
            check({tag, "_imm"},     bif.imm,       head.imm);
            check({tag, "_illegal"}, bif.illegal,   head.illegal);
            if (bif.out_ready) begin
               void'(q.pop_front());
               n_out++;
            end
         end
      end
   end

   task automatic offer(input logic [L-1:0] m, input logic [31:0] w1, input logic [31:0] w0);
      bif.in_valid = 1'b1;
      bif.in_mask  = m;
      bif.ins      = {w1, w0};
   endtask

   task automatic accept();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bif.in_ready && n < 50);
      if (!bif.in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: in_ready got %b, required 1", bif.in_ready);
      end else begin
         q.push_back(model(bif.in_mask, bif.ins));
      end
      @(posedge clk);
      #1;
      bif.in_valid = 1'b0;
   endtask

   task automatic send(input logic [L-1:0] m, input logic [31:0] w1, input logic [31:0] w0);
      offer(m, w1, w0);
      accept();
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_empty", q.size(), 0);
   endtask

   function automatic logic [31:0] rand_word();
      logic [6:0] ops [14] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                                7'h13, 7'h33, 7'h73, 7'h0F, 7'h2F, 7'h7F, 7'h0B};
      logic [31:0] w;
      w = $urandom();
      if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 13)];
      return w;
   endfunction

   initial begin
      bit done;
      int base;
      rstn = 1'b0;
      flush = 1'b0;
      bif.in_valid = 1'b0;
      bif.in_mask = '0;
      bif.ins = '0;
      bif.out_ready = 1'b1;
      sif.in_valid = 1'b0;
      sif.in_mask = '0;
      sif.ins = '0;
      sif.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2 rstn = 1'b1;
      @(posedge clk);
      #1;
      check("rst_out_valid", bif.out_valid, 0);
      check("rst_in_ready",  bif.in_ready,  1);
      check("rst_out_mask",  bif.out_mask,  0);
      check("rst_type",      bif.lane_type, 0);
      check("rst_imm",       bif.imm,       0);
      check("rst_illegal",   bif.illegal,   0);
      check("rst_stall_cnt", stall_cnt,     0);

      // Directed decode vectors; outputs are visible one cycle after the transfer.
      send(2'b11, 32'h12345037, 32'hFFF00093);
      check("d1_valid", bif.out_valid, 1);
      check("d1_type",  bif.lane_type, {3'd4, 3'd1});
      check("d1_imm",   bif.imm, {32'h12345000, 32'hFFFFFFFF});
      check("d1_ill",   bif.illegal, 2'b00);
      send(2'b11, 32'hFE112C23, 32'hFE000FE3);
      check("d2_type",  bif.lane_type, {3'd2, 3'd3});
      // Lane 0 has ins[11:8]=4'hF and ins[7]=1, so the branch offset is -2.
      check("d2_imm",   bif.imm, {32'hFFFFFFF8, 32'hFFFFFFFE});
      send(2'b11, 32'h00000000, 32'h0080006F);
      check("d3_type",  bif.lane_type, {3'd6, 3'd5});
      check("d3_imm",   bif.imm, {32'h0, 32'h00000008});
      check("d3_ill",   bif.illegal, 2'b10);
      send(2'b01, 32'h00000000, 32'h0080006F);
      check("d4_type",  bif.lane_type, {3'd6, 3'd5});
      check("d4_ill",   bif.illegal, 2'b00);
      drain();
      check("d_stall_cnt", stall_cnt, 0);

      // Back-pressure: A in OR, B in skid, C stalls upstream.
      base = n_out;
      bif.out_ready = 1'b0;
      send(2'b11, 32'h00500513, 32'h00100093);
      send(2'b10, 32'h0000006F, 32'hDEADBEEF);
      check("bp_in_ready_low", bif.in_ready, 0);
      check("bp_stall_1", stall_cnt, 1);
      offer(2'b11, 32'h40B50533, 32'hABCDE0B7);
      repeat (6) @(posedge clk);
      #1;
      check("bp_stall_7", stall_cnt, 7);
      check("bp_c_blocked", bif.in_ready, 0);
      bif.out_ready = 1'b1;
      accept();
      drain();
      check("bp_out_count", n_out - base, 3);

      // Flush with OR and skid full while a new bundle is offered.
      bif.out_ready = 1'b0;
      send(2'b11, 32'h00002083, 32'h00112023);
      send(2'b11, 32'h0000000F, 32'h00000073);
      check("fl_full", bif.in_ready, 0);
      offer(2'b11, 32'h00100093, 32'h00200113);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      bif.in_valid = 1'b0;
      q.delete();
      check("fl_out_valid", bif.out_valid, 0);
      check("fl_in_ready",  bif.in_ready,  1);
      base = n_out;
      bif.out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("fl_no_emit", n_out - base, 0);

      // Random traffic with random back-pressure.
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
               send(L'($urandom()), rand_word(), rand_word());
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               bif.out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      bif.out_ready = 1'b1;
      drain();

      // Saturation on the narrow counter, then asynchronous reset in the middle of a stall.
      sif.in_valid = 1'b1;
      sif.in_mask  = 2'b11;
      sif.ins      = {32'h00000013, 32'h00000013};
      bif.out_ready = 1'b0;
      send(2'b11, 32'h00000033, 32'h00000037);
      sif.in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("sat_stall_cnt", stall_sat, 4'hF);
      #3 rstn = 1'b0;
      #1;
      q.delete();
      check("rs_out_valid", bif.out_valid, 0);
      check("rs_in_ready",  bif.in_ready,  1);
      check("rs_out_mask",  bif.out_mask,  0);
      check("rs_type",      bif.lane_type, 0);
      check("rs_imm",       bif.imm,       0);
      check("rs_illegal",   bif.illegal,   0);
      check("rs_stall_cnt", stall_cnt,     0);
      check("rs_sat_cnt",   stall_sat,     0);
      check("rs_sat_valid", sif.out_valid, 0);
      @(posedge clk);
      #2 rstn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rs_no_emit", bif.out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
